// File: rtl/hazard_unit_param_pkg.sv
// Shared definitions for the parametrised hazard unit.
//   - Forwarding select codes driven onto the E-stage operand muxes.
//   - Hazard FSM state codes (also exported on hz_state for debug).
//   - Width of the sequencing down-counter and a helper that turns a
//     cycle count into the counter preload value.
package hazard_unit_param_pkg;

  // Forwarding select codes.
  localparam logic [1:0] FWD_NORMAL    = 2'b00;
  localparam logic [1:0] FWD_WRITEMEM  = 2'b01;
  localparam logic [1:0] FWD_WRITEBACK = 2'b10;

  // Hazard FSM states.
  localparam logic [1:0] HZ_IDLE     = 2'd0;
  localparam logic [1:0] HZ_LU_STALL = 2'd1;
  localparam logic [1:0] HZ_BR_FLUSH = 2'd2;

  localparam int CNT_W = 3;

  // The first cycle of a multi-cycle event is produced straight from
  // IDLE, and the last one is the cycle where cnt reads zero, so the
  // preload for an N-cycle event is N-2.
  function automatic logic [CNT_W-1:0] cnt_preload(input int cycles);
    return (cycles > 1) ? CNT_W'(cycles - 2) : '0;
  endfunction

endpackage

// File: rtl/hazard_unit_param_if.sv
// Bundle of datapath <-> hazard unit signals.
//   master : datapath side, drives pipeline status, receives controls.
//   slave  : hazard unit side.
// Inputs : Dsrc_addr/Dsrc_used (D-stage operands), Esrc_addr, Ewrite_reg_addr,
//          Emem_read, M/W destination address + write enable, branch_sig,
//          mem_busy.
// Outputs: forwardE (2 bits per operand), stallF/D/E/M, flushD/E/W,
//          hz_state.
interface hazard_unit_param_if #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2
);
  logic [NUM_SRC*REG_ADDR_W-1:0] Dsrc_addr;
  logic [NUM_SRC-1:0]            Dsrc_used;
  logic [NUM_SRC*REG_ADDR_W-1:0] Esrc_addr;
  logic [REG_ADDR_W-1:0]         Ewrite_reg_addr;
  logic                          Emem_read;
  logic [REG_ADDR_W-1:0]         Mwrite_reg_addr;
  logic                          Mwrite_reg_sig;
  logic [REG_ADDR_W-1:0]         Wwrite_reg_addr;
  logic                          Wwrite_reg_sig;
  logic                          branch_sig;
  logic                          mem_busy;
  logic [2*NUM_SRC-1:0]          forwardE;
  logic                          stallF, stallD, stallE, stallM;
  logic                          flushD, flushE, flushW;
  logic [1:0]                    hz_state;

  modport master (
    output Dsrc_addr, Dsrc_used, Esrc_addr, Ewrite_reg_addr, Emem_read,
           Mwrite_reg_addr, Mwrite_reg_sig, Wwrite_reg_addr, Wwrite_reg_sig,
           branch_sig, mem_busy,
    input  forwardE, stallF, stallD, stallE, stallM, flushD, flushE, flushW,
           hz_state
  );

  modport slave (
    input  Dsrc_addr, Dsrc_used, Esrc_addr, Ewrite_reg_addr, Emem_read,
           Mwrite_reg_addr, Mwrite_reg_sig, Wwrite_reg_addr, Wwrite_reg_sig,
           branch_sig, mem_busy,
    output forwardE, stallF, stallD, stallE, stallM, flushD, flushE, flushW,
           hz_state
  );
endinterface

// File: rtl/hazard_unit_param_fwd_sel.sv
// Single-operand forwarding comparator.
//   src_addr        : E-stage source register address
//   m_addr, m_write : M-stage destination and write enable
//   w_addr, w_write : W-stage destination and write enable
//   sel             : FWD_NORMAL / FWD_WRITEMEM / FWD_WRITEBACK
// The younger M-stage result wins over W; register 0 is never forwarded.
module hazard_fwd_sel
  import hazard_unit_param_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src_addr,
  input  logic [REG_ADDR_W-1:0] m_addr,
  input  logic                  m_write,
  input  logic [REG_ADDR_W-1:0] w_addr,
  input  logic                  w_write,
  output logic [1:0]            sel
);

  always_comb begin
    sel = FWD_NORMAL;
    if (src_addr != '0) begin
      if (m_write && (src_addr == m_addr)) begin
        sel = FWD_WRITEMEM;
      end else if (w_write && (src_addr == w_addr)) begin
        sel = FWD_WRITEBACK;
      end
    end
  end

endmodule

// File: rtl/hazard_unit_param.sv
// Parametrised pipeline hazard controller.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   hz    : hazard_unit_param_if.slave (pipeline status in, controls out)
// Produces per-operand E-stage forwarding selects, load-use stalls of
// LOAD_LAT cycles, FLUSH_CYCLES-long branch flushes of D, and a whole-pipe
// freeze while data memory is busy.
module hazard_unit_param
  import hazard_unit_param_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int NUM_SRC      = 2,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1
) (
  input logic             clk,
  input logic             reset,
  hazard_unit_param_if.slave hz
);

  localparam logic [CNT_W-1:0] LU_PRELOAD = cnt_preload(LOAD_LAT);
  localparam logic [CNT_W-1:0] BR_PRELOAD = cnt_preload(FLUSH_CYCLES);

  logic [2*NUM_SRC-1:0] fwd_raw;
  logic [NUM_SRC-1:0]   src_hit;
  logic                 load_use;

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_w;

  // Per-operand forwarding and load-use dependency detection.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_sel (
      .src_addr (hz.Esrc_addr[gi*REG_ADDR_W +: REG_ADDR_W]),
      .m_addr   (hz.Mwrite_reg_addr),
      .m_write  (hz.Mwrite_reg_sig),
      .w_addr   (hz.Wwrite_reg_addr),
      .w_write  (hz.Wwrite_reg_sig),
      .sel      (fwd_raw[2*gi +: 2])
    );

    assign src_hit[gi] = hz.Dsrc_used[gi] &&
                         (hz.Dsrc_addr[gi*REG_ADDR_W +: REG_ADDR_W] == hz.Ewrite_reg_addr);
  end

  assign load_use = hz.Emem_read && (hz.Ewrite_reg_addr != '0) && (|src_hit);

  // Stall/flush sequencing; each branch below is one priority level.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;

    if (reset) begin
      state_next = HZ_IDLE;
      cnt_next   = '0;
    end else if (hz.mem_busy) begin
      // Freeze everything; W gets a bubble since M cannot retire.
      // FSM state and counter hold so the interrupted sequence resumes.
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (hz.branch_sig) begin
      // Restarts the flush sequence even if one is already running.
      flush_d = 1'b1;
      flush_e = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_next = HZ_BR_FLUSH;
        cnt_next   = BR_PRELOAD;
      end else begin
        state_next = HZ_IDLE;
        cnt_next   = '0;
      end
    end else begin
      case (state_reg)
        HZ_IDLE: begin
          if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
            if (LOAD_LAT > 1) begin
              state_next = HZ_LU_STALL;
              cnt_next   = LU_PRELOAD;
            end
          end
        end
        HZ_LU_STALL: begin
          // E holds a bubble here, so load_use is not re-evaluated.
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
          if (cnt_reg == '0) state_next = HZ_IDLE;
          else               cnt_next   = cnt_reg - 1'b1;
        end
        HZ_BR_FLUSH: begin
          // D holds a wrong-path instruction, so load_use is ignored.
          flush_d = 1'b1;
          if (cnt_reg == '0) state_next = HZ_IDLE;
          else               cnt_next   = cnt_reg - 1'b1;
        end
        default: begin
          state_next = HZ_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= HZ_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign hz.forwardE = reset ? '0 : fwd_raw;
  assign hz.stallF   = stall_f;
  assign hz.stallD   = stall_d;
  assign hz.stallE   = stall_e;
  assign hz.stallM   = stall_m;
  assign hz.flushD   = flush_d;
  assign hz.flushE   = flush_e;
  assign hz.flushW   = flush_w;
  assign hz.hz_state = state_reg;

endmodule

// File: tb/tb_hazard_unit_param.sv
// Directed bench for hazard_unit_param. Two instances share one stimulus
// set: dut_a (LOAD_LAT=1, FLUSH_CYCLES=3) and dut_b (LOAD_LAT=3,
// FLUSH_CYCLES=3). Control outputs are checked as a packed vector
// {stallF,stallD,stallE,stallM,flushD,flushE,flushW}.
module tb_hazard_unit_param;

  localparam int AW = 5;
  localparam int NS = 2;

  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_STALL = 7'b1100010;
  localparam logic [6:0] C_BR0   = 7'b0000110;
  localparam logic [6:0] C_BRF   = 7'b0000100;
  localparam logic [6:0] C_BUSY  = 7'b1111001;

  logic clk = 1'b0;
  logic rst;

  logic [NS*AW-1:0] dsrc_addr, esrc_addr;
  logic [NS-1:0]    dsrc_used;
  logic [AW-1:0]    e_wr_addr, m_wr_addr, w_wr_addr;
  logic             e_mem_read, m_we, w_we, branch, mem_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_unit_param_if #(.REG_ADDR_W(AW), .NUM_SRC(NS)) if_a ();
  hazard_unit_param_if #(.REG_ADDR_W(AW), .NUM_SRC(NS)) if_b ();

  assign if_a.Dsrc_addr = dsrc_addr;        assign if_b.Dsrc_addr = dsrc_addr;
  assign if_a.Dsrc_used = dsrc_used;        assign if_b.Dsrc_used = dsrc_used;
  assign if_a.Esrc_addr = esrc_addr;        assign if_b.Esrc_addr = esrc_addr;
  assign if_a.Ewrite_reg_addr = e_wr_addr;  assign if_b.Ewrite_reg_addr = e_wr_addr;
  assign if_a.Emem_read = e_mem_read;       assign if_b.Emem_read = e_mem_read;
  assign if_a.Mwrite_reg_addr = m_wr_addr;  assign if_b.Mwrite_reg_addr = m_wr_addr;
  assign if_a.Mwrite_reg_sig = m_we;        assign if_b.Mwrite_reg_sig = m_we;
  assign if_a.Wwrite_reg_addr = w_wr_addr;  assign if_b.Wwrite_reg_addr = w_wr_addr;
  assign if_a.Wwrite_reg_sig = w_we;        assign if_b.Wwrite_reg_sig = w_we;
  assign if_a.branch_sig = branch;          assign if_b.branch_sig = branch;
  assign if_a.mem_busy = mem_busy;          assign if_b.mem_busy = mem_busy;

  hazard_unit_param #(.REG_ADDR_W(AW), .NUM_SRC(NS), .LOAD_LAT(1), .FLUSH_CYCLES(3)) dut_a (
    .clk(clk), .reset(rst), .hz(if_a)
  );
  hazard_unit_param #(.REG_ADDR_W(AW), .NUM_SRC(NS), .LOAD_LAT(3), .FLUSH_CYCLES(3)) dut_b (
    .clk(clk), .reset(rst), .hz(if_b)
  );

  logic [6:0] ctl_a, ctl_b;
  assign ctl_a = {if_a.stallF, if_a.stallD, if_a.stallE, if_a.stallM,
                  if_a.flushD, if_a.flushE, if_a.flushW};
  assign ctl_b = {if_b.stallF, if_b.stallD, if_b.stallE, if_b.stallM,
                  if_b.flushD, if_b.flushE, if_b.flushW};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end else begin
      $display("check %-16s ok (%0h)", tag, obs);
    end
  endtask

  // Advance one cycle; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    dsrc_addr = '0; esrc_addr = '0; dsrc_used = '0;
    e_wr_addr = '0; m_wr_addr = '0; w_wr_addr = '0;
    e_mem_read = 1'b0; m_we = 1'b0; w_we = 1'b0;
    branch = 1'b0; mem_busy = 1'b0;
  endtask

  // Settle combinational outputs, then compare well before the next edge.
  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    // Forwarding inputs that would hit, to prove reset forces NORMAL.
    esrc_addr = {5'd3, 5'd3};
    m_wr_addr = 5'd3; m_we = 1'b1;
    w_wr_addr = 5'd3; w_we = 1'b1;
    tick(); tick(); settle();
    check_eq("rst_fwd_a", 32'(if_a.forwardE), 32'h0);
    check_eq("rst_ctl_a", 32'(ctl_a), 32'(C_NONE));
    check_eq("rst_state_a", 32'(if_a.hz_state), 32'd0);
    check_eq("rst_state_b", 32'(if_b.hz_state), 32'd0);

    // ---- forwarding ----
    rst = 1'b0; settle();
    check_eq("fwd_mm", 32'(if_a.forwardE), 32'b0101);
    m_we = 1'b0; settle();
    check_eq("fwd_ww", 32'(if_a.forwardE), 32'b1010);
    esrc_addr = '0; m_wr_addr = '0; w_wr_addr = '0; m_we = 1'b1; settle();
    check_eq("fwd_zero", 32'(if_a.forwardE), 32'b0000);
    esrc_addr = {5'd4, 5'd3}; m_wr_addr = 5'd3; w_wr_addr = 5'd4; settle();
    check_eq("fwd_mix", 32'(if_a.forwardE), 32'b1001);
    clear_inputs();
    tick();

    // ---- load-use, both latencies ----
    e_mem_read = 1'b1; e_wr_addr = 5'd5; dsrc_addr = {5'd5, 5'd0}; dsrc_used = 2'b10;
    settle();
    check_eq("lu_a_c0", 32'(ctl_a), 32'(C_STALL));
    check_eq("lu_b_c0", 32'(ctl_b), 32'(C_STALL));
    tick();
    e_mem_read = 1'b0; settle();    // bubble now in E
    check_eq("lu_a_c1", 32'(ctl_a), 32'(C_NONE));
    check_eq("lu_a_st1", 32'(if_a.hz_state), 32'd0);
    check_eq("lu_b_c1", 32'(ctl_b), 32'(C_STALL));
    check_eq("lu_b_st1", 32'(if_b.hz_state), 32'd1);
    tick(); settle();
    check_eq("lu_b_c2", 32'(ctl_b), 32'(C_STALL));
    check_eq("lu_b_st2", 32'(if_b.hz_state), 32'd1);
    tick(); settle();
    check_eq("lu_b_c3", 32'(ctl_b), 32'(C_NONE));
    check_eq("lu_b_st3", 32'(if_b.hz_state), 32'd0);

    // Operand 1 matches but is not read: no hazard.
    e_mem_read = 1'b1; e_wr_addr = 5'd5; dsrc_addr = {5'd5, 5'd0}; dsrc_used = 2'b01;
    settle();
    check_eq("lu_unused", 32'(ctl_a), 32'(C_NONE));
    clear_inputs();
    tick();

    // ---- branch flush, FLUSH_CYCLES=3 ----
    branch = 1'b1; settle();
    check_eq("br_c0", 32'(ctl_a), 32'(C_BR0));
    tick(); branch = 1'b0; settle();
    check_eq("br_c1", 32'(ctl_a), 32'(C_BRF));
    check_eq("br_st1", 32'(if_a.hz_state), 32'd2);
    tick(); settle();
    check_eq("br_c2", 32'(ctl_a), 32'(C_BRF));
    tick(); settle();
    check_eq("br_c3", 32'(ctl_a), 32'(C_NONE));
    check_eq("br_st3", 32'(if_a.hz_state), 32'd0);

    // Second branch mid-flush restarts the sequence.
    branch = 1'b1; settle();
    tick(); branch = 1'b0; settle();
    check_eq("brr_c1", 32'(ctl_a), 32'(C_BRF));
    tick(); branch = 1'b1; settle();
    check_eq("brr_c2", 32'(ctl_a), 32'(C_BR0));
    tick(); branch = 1'b0; settle();
    check_eq("brr_c3", 32'(ctl_a), 32'(C_BRF));
    tick(); settle();
    check_eq("brr_c4", 32'(ctl_a), 32'(C_BRF));
    tick(); settle();
    check_eq("brr_c5", 32'(ctl_a), 32'(C_NONE));

    // ---- mem_busy freeze during LU_STALL (dut_b) ----
    e_mem_read = 1'b1; e_wr_addr = 5'd5; dsrc_addr = {5'd5, 5'd0}; dsrc_used = 2'b10;
    settle();
    check_eq("mb_c0", 32'(ctl_b), 32'(C_STALL));
    tick(); clear_inputs(); settle();
    check_eq("mb_c1", 32'(ctl_b), 32'(C_STALL));
    tick();
    mem_busy = 1'b1; esrc_addr = {5'd0, 5'd3}; m_wr_addr = 5'd3; m_we = 1'b1; settle();
    check_eq("mb_busy0", 32'(ctl_b), 32'(C_BUSY));
    check_eq("mb_fwd", 32'(if_b.forwardE), 32'b0001);
    tick(); settle();
    check_eq("mb_busy1", 32'(ctl_b), 32'(C_BUSY));
    check_eq("mb_st_hold", 32'(if_b.hz_state), 32'd1);
    tick(); clear_inputs(); settle();
    check_eq("mb_resume", 32'(ctl_b), 32'(C_STALL));
    tick(); settle();
    check_eq("mb_done", 32'(ctl_b), 32'(C_NONE));
    check_eq("mb_st_done", 32'(if_b.hz_state), 32'd0);

    // ---- reset mid-BR_FLUSH ----
    branch = 1'b1; settle();
    tick(); branch = 1'b0; settle();
    check_eq("rb_st", 32'(if_a.hz_state), 32'd2);
    rst = 1'b1; esrc_addr = {5'd3, 5'd3}; m_wr_addr = 5'd3; m_we = 1'b1; settle();
    check_eq("rb_ctl_rst", 32'(ctl_a), 32'(C_NONE));
    check_eq("rb_fwd_rst", 32'(if_a.forwardE), 32'h0);
    tick(); settle();
    check_eq("rb_st_rst", 32'(if_a.hz_state), 32'd0);
    check_eq("rb_ctl_next", 32'(ctl_a), 32'(C_NONE));
    rst = 1'b0; clear_inputs();
    tick(); settle();
    check_eq("rb_idle", 32'(ctl_a), 32'(C_NONE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit_param.md
Name: hazard_unit_param

Overview:
- Parametrised successor to the 5-stage hazard controller.
- Generates per-operand E-stage forwarding selects for NUM_SRC source operands.
- Adds sequential hazard handling:
  - load-use stalls lasting LOAD_LAT cycles,
  - multi-cycle branch flush lasting FLUSH_CYCLES cycles,
  - whole-pipe freeze on data-memory busy.
- Sits beside the datapath; its outputs drive the F/D/E/M pipeline-register enables and clears, and the E-stage operand muxes.

Parameters:
- REG_ADDR_W, 5: register address width; address 0 is hardwired zero.
- NUM_SRC, 2: number of source operands per instruction (1..4).
- LOAD_LAT, 1: load-use stall cycles (1..7).
- FLUSH_CYCLES, 1: cycles flushD is held after a taken branch (1..7).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- Dsrc_addr  in  NUM_SRC*REG_ADDR_W  D-stage source register addresses; operand i at [i*REG_ADDR_W +: REG_ADDR_W].
- Dsrc_used  in  NUM_SRC  D-stage operand i is actually read.
- Esrc_addr  in  NUM_SRC*REG_ADDR_W  E-stage source register addresses.
- Ewrite_reg_addr  in  REG_ADDR_W  destination register of the instruction in E.
- Emem_read  in  1  instruction in E is a load.
- Mwrite_reg_addr  in  REG_ADDR_W  M-stage destination register.
- Mwrite_reg_sig  in  1  M-stage writes a register.
- Wwrite_reg_addr  in  REG_ADDR_W  W-stage destination register.
- Wwrite_reg_sig  in  1  W-stage writes a register.
- branch_sig  in  1  taken branch/jump resolved in E.
- mem_busy  in  1  data memory not ready this cycle.
- forwardE  out  2*NUM_SRC  forwarding select; operand i at [2i+:2].
- stallF, stallD, stallE, stallM  out  1 each  hold the corresponding pipeline register.
- flushD, flushE, flushW  out  1 each  insert a bubble into D, E or W.
- hz_state  out  2  FSM state, for debug.

Behaviour:
- Forwarding (combinational), per operand i:
  - WRITEMEM if Mwrite_reg_sig, the address is non-zero and equals Mwrite_reg_addr;
  - else WRITEBACK if Wwrite_reg_sig, the address is non-zero and equals Wwrite_reg_addr;
  - else NORMAL.
  - M has priority over W.
  - Forced to NORMAL while reset is high.
- load_use (combinational) = Emem_read AND Ewrite_reg_addr != 0 AND, for some i, Dsrc_used[i] with Dsrc_addr[i] == Ewrite_reg_addr.
- FSM states: IDLE=0, LU_STALL=1, BR_FLUSH=2. It also has a 3-bit down-counter cnt.
- Reset:
  - state=IDLE, cnt=0.
  - While reset is high, every stall/flush output is 0.
- Priority, evaluated each cycle from highest to lowest:
  1. reset
  2. mem_busy
  3. branch_sig
  4. load_use / LU_STALL
  5. BR_FLUSH
  6. IDLE
- mem_busy:
  - stallF=stallD=stallE=stallM=1 and flushW=1; all other flushes 0.
  - FSM state and cnt hold their values.
  - branch_sig and load_use are ignored this cycle; they re-present when mem_busy drops.
- branch_sig (no mem_busy):
  - flushD=flushE=1 this cycle; no stalls.
  - FLUSH_CYCLES>1: next state BR_FLUSH with cnt=FLUSH_CYCLES-2; else IDLE.
  - Aborts LU_STALL or BR_FLUSH in progress and restarts from the current cycle.
- load_use in IDLE:
  - stallF=stallD=1 and flushE=1 this cycle.
  - LOAD_LAT>1: next state LU_STALL with cnt=LOAD_LAT-2; else IDLE.
- LU_STALL:
  - stallF=stallD=flushE=1.
  - cnt==0: next state IDLE; else cnt-1.
  - load_use is not re-evaluated here (E holds a bubble).
- BR_FLUSH:
  - flushD=1 only.
  - load_use is suppressed (D is invalid).
  - cnt==0: next state IDLE; else cnt-1.
- A flush and a stall on the same register never assert together, except stallD with flushE (legal).
- hz_state equals the registered state.
- Forwarding stays active in every state and during mem_busy.

Decomposition:
- Shared include (99_define.vh), extended with:
  - forwarding codes NORMAL=2'b00, WRITEMEM=2'b01, WRITEBACK=2'b10;
  - FSM state codes HZ_IDLE, HZ_LU_STALL, HZ_BR_FLUSH.
- One sub-module, hazard_fwd_sel: a single-operand forwarding comparator, parametrised on REG_ADDR_W and instantiated NUM_SRC times in a generate loop.
- FSM and counter live in the top module.

Test Plan:
- Forwarding: Esrc_addr op0=3, op1=3; M writes r3; W writes r3 -> forwardE={01,01}.
  - Then drop Mwrite_reg_sig -> {10,10}.
  - All addresses 0 with both writes high -> {00,00}.
- Load-use with LOAD_LAT=1: Emem_read=1, Ewrite_reg_addr=5, Dsrc_addr op1=5, used -> one cycle of stallF=stallD=flushE=1, then IDLE with all outputs 0.
  - With Dsrc_used[1]=0 -> no stall.
- Load-use with LOAD_LAT=3: same stimulus -> stallF/stallD/flushE high for exactly 3 cycles; hz_state goes 0,1,1,0.
- Branch with FLUSH_CYCLES=3: branch_sig pulse -> cycle 0 flushD=flushE=1, then flushD=1 only for 2 cycles, then IDLE.
  - A second branch_sig during BR_FLUSH restarts the 3-cycle sequence.
- mem_busy held 2 cycles mid-LU_STALL (LOAD_LAT=3) -> stallF..stallM=1 and flushW=1 for 2 cycles; cnt frozen; the remaining LU_STALL cycles complete afterwards, 3 stall cycles total excluding the freeze.
- Reset asserted mid-BR_FLUSH -> next cycle hz_state=0 and all flush/stall outputs 0; forwardE=00 while reset is high.
